// File: rtl/enc_out_streamer.sv
// Captures the dense encoder's output vector on completion and streams it out LANES elements per beat,
// tracking the argmax of the streamed values. Define ENC_OUT_RELU_EN to clamp negative elements to 0 at capture.
module enc_out_streamer #(
   parameter int BITSIZE  = 16,
   parameter int VEC_SIZE = 92,
   parameter int LANES    = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [BITSIZE*VEC_SIZE-1:0]   y_in,
   input  logic                          done_in,
   output logic [BITSIZE*LANES-1:0]      out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_last,
   output logic [$clog2(VEC_SIZE):0]     out_index,
   output logic                          busy,
   output logic                          frame_done,
   output logic [$clog2(VEC_SIZE)-1:0]   max_idx,
   output logic [BITSIZE-1:0]            max_val,
   output logic                          drop_flag
);

   localparam int IDXW     = $clog2(VEC_SIZE) + 1;
   localparam int EW       = $clog2(VEC_SIZE);
   localparam int NBEATS   = (VEC_SIZE + LANES - 1) / LANES;
   localparam int LASTBASE = (NBEATS - 1) * LANES;
   localparam logic signed [BITSIZE-1:0] MOST_NEG = {1'b1, {(BITSIZE-1){1'b0}}};

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                     state_q, state_d;
   logic                       done_q;
   logic                       armed_q;
   logic [BITSIZE-1:0]         frame_buf [VEC_SIZE];
   logic [IDXW-1:0]            base_q;
   logic [EW-1:0]              run_idx_q;
   logic signed [BITSIZE-1:0]  run_val_q;
   logic                       capture;
   logic                       accept;
   logic                       final_beat;
   logic [IDXW:0]              lane_pos;
   logic [BITSIZE*LANES-1:0]   beat_data;
   logic [EW-1:0]              beat_idx;
   logic signed [BITSIZE-1:0]  beat_val;

   // A done level already high when reset releases is not a rising edge; armed_q waits for it to go low first.
   assign capture    = done_in & ~done_q & armed_q;
   assign accept     = (state_q == STREAM) & out_ready;
   assign final_beat = (base_q == IDXW'(LASTBASE));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (capture) state_d = STREAM;
         STREAM:  if (accept && final_beat) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Lanes past the vector end read as zero and never compete; ascending lane order keeps ties at the lowest index.
   always_comb begin
      beat_data = '0;
      beat_idx  = run_idx_q;
      beat_val  = run_val_q;
      lane_pos  = '0;
      for (int j = 0; j < LANES; j++) begin
         lane_pos = {1'b0, base_q} + (IDXW+1)'(j);
         if (lane_pos < (IDXW+1)'(VEC_SIZE)) begin
            beat_data[j*BITSIZE +: BITSIZE] = frame_buf[lane_pos[EW-1:0]];
            if ($signed(frame_buf[lane_pos[EW-1:0]]) > beat_val) begin
               beat_val = $signed(frame_buf[lane_pos[EW-1:0]]);
               beat_idx = lane_pos[EW-1:0];
            end
         end
      end
   end

   assign out_valid = (state_q == STREAM);
   assign busy      = (state_q == STREAM);
   assign out_last  = (state_q == STREAM) & final_beat;
   assign out_data  = (state_q == STREAM) ? beat_data : '0;
   assign out_index = base_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         done_q     <= 1'b0;
         armed_q    <= 1'b0;
         base_q     <= '0;
         run_idx_q  <= '0;
         run_val_q  <= MOST_NEG;
         frame_done <= 1'b0;
         max_idx    <= '0;
         max_val    <= '0;
         drop_flag  <= 1'b0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_in;
         frame_done <= 1'b0;
         if (!done_in) armed_q <= 1'b1;
         if (state_q == IDLE && capture) begin
            base_q    <= '0;
            run_idx_q <= '0;
            run_val_q <= MOST_NEG;
         end else if (accept) begin
            run_idx_q <= beat_idx;
            run_val_q <= beat_val;
            if (final_beat) begin
               base_q     <= '0;
               frame_done <= 1'b1;
               max_idx    <= beat_idx;
               max_val    <= beat_val;
            end else begin
               base_q <= base_q + IDXW'(LANES);
            end
         end
         if (state_q == STREAM && capture) drop_flag <= 1'b1;
      end
   end

   // The frame buffer carries no reset; its contents are only observed after a fresh capture.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && capture) begin
         for (int i = 0; i < VEC_SIZE; i++) begin
`ifdef ENC_OUT_RELU_EN
            frame_buf[i] <= y_in[i*BITSIZE+BITSIZE-1] ? '0 : y_in[i*BITSIZE +: BITSIZE];
`else
            frame_buf[i] <= y_in[i*BITSIZE +: BITSIZE];
`endif
         end
      end
   end

endmodule

// File: tb/tb_enc_out_streamer.sv
// Directed bench for enc_out_streamer: one 4-lane and one 8-lane instance, beats checked
// against hand-built element tables.
module tb_enc_out_streamer;

   localparam int BITSIZE  = 16;
   localparam int VEC_SIZE = 92;
   localparam int P_DATA = 0, P_VALID = 1, P_LAST = 2, P_INDEX = 3, P_BUSY = 4,
                  P_FDONE = 5, P_MIDX = 6, P_MVAL = 7, P_DROP = 8;

   logic                        clk = 1'b0;
   logic                        reset;
   logic [BITSIZE*VEC_SIZE-1:0] y_in;
   logic                        done4, done8, ready4, ready8;
   logic [63:0]                 data4;
   logic [127:0]                data8;
   logic                        valid4, valid8, last4, last8, busy4, busy8;
   logic                        fd4, fd8, drop4, drop8;
   logic [7:0]                  index4, index8;
   logic [6:0]                  midx4, midx8;
   logic [15:0]                 mval4, mval8;
   int                          vectors = 0;
   int                          miscompares = 0;
   logic [15:0]                 exp_elem [VEC_SIZE];

   always #5 clk = ~clk;

   enc_out_streamer #(.BITSIZE(16), .VEC_SIZE(92), .LANES(4)) dut4 (
      .clk(clk), .reset(reset), .y_in(y_in), .done_in(done4),
      .out_data(data4), .out_valid(valid4), .out_ready(ready4), .out_last(last4),
      .out_index(index4), .busy(busy4), .frame_done(fd4), .max_idx(midx4),
      .max_val(mval4), .drop_flag(drop4)
   );

   enc_out_streamer #(.BITSIZE(16), .VEC_SIZE(92), .LANES(8)) dut8 (
      .clk(clk), .reset(reset), .y_in(y_in), .done_in(done8),
      .out_data(data8), .out_valid(valid8), .out_ready(ready8), .out_last(last8),
      .out_index(index8), .busy(busy8), .frame_done(fd8), .max_idx(midx8),
      .max_val(mval8), .drop_flag(drop8)
   );

   // Compares one observed value with its expected value and logs any miscompare.
   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Picks an output of whichever instance a test targets.
   function automatic logic [127:0] probe(input int lanes, input int sel);
      logic [127:0] r;
      r = '0;
      case (sel)
         P_DATA:  r = (lanes == 8) ? data8 : 128'(data4);
         P_VALID: r = 128'((lanes == 8) ? valid8 : valid4);
         P_LAST:  r = 128'((lanes == 8) ? last8 : last4);
         P_INDEX: r = 128'((lanes == 8) ? index8 : index4);
         P_BUSY:  r = 128'((lanes == 8) ? busy8 : busy4);
         P_FDONE: r = 128'((lanes == 8) ? fd8 : fd4);
         P_MIDX:  r = 128'((lanes == 8) ? midx8 : midx4);
         P_MVAL:  r = 128'((lanes == 8) ? mval8 : mval4);
         P_DROP:  r = 128'((lanes == 8) ? drop8 : drop4);
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic setDone(input int lanes, input logic v);
      if (lanes == 8) done8 = v; else done4 = v;
   endtask

   task automatic setReady(input int lanes, input logic v);
      if (lanes == 8) ready8 = v; else ready4 = v;
   endtask

   // Loads y_in and the expected post-activation element table: 0 = ramp i*16, 1 = negative pattern.
   task automatic applyStimulus(input int pattern);
      logic [15:0] v;
      for (int i = 0; i < VEC_SIZE; i++) begin
         if (pattern == 0) v = 16'(i * 16);
         else              v = (i == 5) ? 16'hF800 : 16'hFFFF;
         y_in[i*BITSIZE +: BITSIZE] = v;
`ifdef ENC_OUT_RELU_EN
         exp_elem[i] = v[15] ? 16'h0000 : v;
`else
         exp_elem[i] = v;
`endif
      end
   endtask

   // Raises done, then checks every cycle of the frame; stalls must keep the current beat unchanged.
   task automatic streamFrame(input int lanes, input bit toggle, input int drop_beat,
                              input logic [6:0] exp_idx, input logic [15:0] exp_val);
      int beats;
      int k;
      int cyc;
      bit rdy;
      bit dropped;
      logic [127:0] exp_data;
      beats   = (VEC_SIZE + lanes - 1) / lanes;
      k       = 0;
      cyc     = 0;
      dropped = 0;
      setReady(lanes, 1'b1);
      setDone(lanes, 1'b1);
      @(negedge clk);
      while (k < beats && cyc < 100) begin
         exp_data = '0;
         for (int j = 0; j < lanes; j++)
            if (k*lanes + j < VEC_SIZE) exp_data[j*16 +: 16] = exp_elem[k*lanes + j];
         checkOutput("out_valid", probe(lanes, P_VALID), 128'(1));
         checkOutput("busy", probe(lanes, P_BUSY), 128'(1));
         checkOutput("out_data", probe(lanes, P_DATA), exp_data);
         checkOutput("out_index", probe(lanes, P_INDEX), 128'(k*lanes));
         checkOutput("out_last", probe(lanes, P_LAST), 128'(k == beats-1));
         if (cyc == 1) setDone(lanes, 1'b0);
         if (drop_beat >= 0 && k == drop_beat && !dropped) begin
            setDone(lanes, 1'b1);
            dropped = 1;
         end
         rdy = toggle ? (cyc % 2 == 0) : 1'b1;
         setReady(lanes, rdy);
         @(negedge clk);
         if (rdy) k++;
         cyc++;
      end
      checkOutput("frame_beats", 128'(k), 128'(beats));
      checkOutput("end_valid", probe(lanes, P_VALID), 128'(0));
      checkOutput("end_busy", probe(lanes, P_BUSY), 128'(0));
      checkOutput("frame_done", probe(lanes, P_FDONE), 128'(1));
      checkOutput("max_idx", probe(lanes, P_MIDX), 128'(exp_idx));
      checkOutput("max_val", probe(lanes, P_MVAL), 128'(exp_val));
      @(negedge clk);
      checkOutput("frame_done_pulse", probe(lanes, P_FDONE), 128'(0));
      checkOutput("no_retrigger", probe(lanes, P_VALID), 128'(0));
      setDone(lanes, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      reset  = 1'b1;
      done4  = 1'b1;
      done8  = 1'b1;
      ready4 = 1'b0;
      ready8 = 1'b0;
      y_in   = '0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_valid", 128'(valid4), 128'(0));
      checkOutput("rst_data", 128'(data4), 128'(0));
      checkOutput("rst_busy", 128'(busy4), 128'(0));
      checkOutput("rst_last", 128'(last4), 128'(0));
      checkOutput("rst_index", 128'(index4), 128'(0));
      checkOutput("rst_fdone", 128'(fd4), 128'(0));
      checkOutput("rst_midx", 128'(midx4), 128'(0));
      checkOutput("rst_mval", 128'(mval4), 128'(0));
      checkOutput("rst_drop", 128'(drop4), 128'(0));
      checkOutput("rst_valid8", 128'(valid8), 128'(0));
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("held_done_valid", 128'(valid4), 128'(0));
      checkOutput("held_done_busy", 128'(busy4), 128'(0));
      checkOutput("held_done_valid8", 128'(valid8), 128'(0));
      done4 = 1'b0;
      done8 = 1'b0;
      @(negedge clk);

      applyStimulus(0);
      streamFrame(4, 1'b0, -1, 7'd91, 16'd1456);

      applyStimulus(1);
`ifdef ENC_OUT_RELU_EN
      streamFrame(4, 1'b0, -1, 7'd0, 16'h0000);
`else
      streamFrame(4, 1'b0, -1, 7'd0, 16'hFFFF);
`endif

      applyStimulus(0);
      streamFrame(8, 1'b1, -1, 7'd91, 16'd1456);

      checkOutput("drop_before", 128'(drop4), 128'(0));
      streamFrame(4, 1'b0, 10, 7'd91, 16'd1456);
      checkOutput("drop_after", 128'(drop4), 128'(1));
      checkOutput("drop_no_frame", 128'(valid4), 128'(0));

      ready4 = 1'b1;
      done4  = 1'b1;
      @(negedge clk);
      done4 = 1'b0;
      repeat (7) @(negedge clk);
      checkOutput("pre_reset_index", 128'(index4), 128'(28));
      reset = 1'b1;
      #1;
      checkOutput("midrst_valid", 128'(valid4), 128'(0));
      checkOutput("midrst_busy", 128'(busy4), 128'(0));
      checkOutput("midrst_index", 128'(index4), 128'(0));
      checkOutput("midrst_drop", 128'(drop4), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_idle", 128'(valid4), 128'(0));
      streamFrame(4, 1'b0, -1, 7'd91, 16'd1456);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
